// File: rtl/uart_bus_bridge_pkg.sv
// Shared types and constants for the UART-to-bus command bridge.
package uart_bus_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS_WR,
        BUS_RD,
        RESP
    } state_e;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    // Number of whole bytes needed to carry an address of the given width.
    function automatic int addr_bytes(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_bus_bridge_if.sv
// Byte-stream and peripheral-bus signals seen by the bridge.
// master = the bridge itself (bus initiator), slave = UART + peripheral side.
interface uart_bus_bridge_if #(
    parameter int address_width = 16
);
    logic [7:0]               rx_data_i;
    logic                     rx_valid_i;
    logic [7:0]               tx_data_o;
    logic                     tx_valid_o;
    logic                     tx_ready_i;
    logic [address_width-1:0] bus_addr_o;
    logic [7:0]               bus_wdata_o;
    logic                     bus_we_o;
    logic                     bus_re_o;
    logic [7:0]               bus_rdata_i;
    logic                     busy_o;
    logic                     err_o;

    modport master (
        input  rx_data_i, rx_valid_i, tx_ready_i, bus_rdata_i,
        output tx_data_o, tx_valid_o, bus_addr_o, bus_wdata_o,
               bus_we_o, bus_re_o, busy_o, err_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, tx_ready_i, bus_rdata_i,
        input  tx_data_o, tx_valid_o, bus_addr_o, bus_wdata_o,
               bus_we_o, bus_re_o, busy_o, err_o
    );
endinterface

// File: rtl/uart_bus_bridge_timer.sv
// Loadable down-counter. expire_o pulses in the last enabled cycle of a
// count, i.e. N enabled cycles after loading N. Load beats clear.
module uart_bus_bridge_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         clear_i,
    input  logic         en_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // Next count: reload, clear, or step down while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign expire_o = en_i && (cnt_q == W'(1));
endmodule

// File: rtl/uart_bus_bridge.sv
// Parses W/R frames from a UART byte stream, runs one bus transaction per
// frame and returns a single response byte (ACK, read data or NAK).
module uart_bus_bridge
    import uart_bus_bridge_pkg::*;
#(
    parameter int FPGAClkSpeed  = 50000000,
    parameter int BaudRate      = 230400,
    parameter int address_width = 16,
    parameter int data_width    = 8,
    parameter int ReadLatency   = 1
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    uart_bus_bridge_if.master bus
);
    localparam int AddrBytes     = addr_bytes(address_width);
    localparam int AddrShW       = AddrBytes * 8;
    localparam int CntW          = $clog2(AddrBytes) + 1;
    localparam int TimeoutCycles = (FPGAClkSpeed / BaudRate) * 100;
    localparam int TmrMax        = (TimeoutCycles > ReadLatency + 1) ? TimeoutCycles : ReadLatency + 1;
    localparam int TmrW          = $clog2(TmrMax + 1);

    if (data_width != 8) begin : g_dw_chk
        $error("uart_bus_bridge: data_width must be 8");
    end
    if (ReadLatency < 1 || ReadLatency > 7) begin : g_rl_chk
        $error("uart_bus_bridge: ReadLatency must be 1..7");
    end

    state_e              state_q, state_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [AddrShW-1:0]  addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          txd_q, txd_d;
    logic [CntW-1:0]     nbytes_q, nbytes_d;
    logic                we_q, we_d, re_q, re_d, err_q, err_d;

    logic                tmr_load, tmr_clear, tmr_en, tmr_exp;
    logic [TmrW-1:0]     tmr_val;

    // One timer serves both the inter-byte timeout and the read-latency wait;
    // loading ReadLatency+1 makes it expire in the sampling cycle.
    uart_bus_bridge_timer #(.W(TmrW)) u_timer (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .clear_i    (tmr_clear),
        .en_i       (tmr_en),
        .expire_o   (tmr_exp)
    );

    // Frame parser / transaction sequencer: next state and register updates.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        txd_d     = txd_q;
        nbytes_d  = nbytes_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        err_d     = 1'b0;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        tmr_val   = TmrW'(TimeoutCycles);
        tmr_en    = (state_q == ADDR) || (state_q == DATA) || (state_q == BUS_RD);

        unique case (state_q)
            IDLE: begin
                tmr_clear = 1'b1;
                if (bus.rx_valid_i) begin
                    if (bus.rx_data_i == CMD_WRITE || bus.rx_data_i == CMD_READ) begin
                        cmd_d    = bus.rx_data_i;
                        nbytes_d = '0;
                        tmr_load = 1'b1;
                        state_d  = ADDR;
                    end else begin
                        txd_d   = RSP_NAK;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ADDR: begin
                // A byte arriving in the expiry cycle wins over the timeout.
                if (bus.rx_valid_i) begin
                    addr_d   = AddrShW'({addr_q, bus.rx_data_i});
                    tmr_load = 1'b1;
                    if (nbytes_q == CntW'(AddrBytes - 1)) begin
                        if (cmd_q == CMD_WRITE) begin
                            state_d = DATA;
                        end else begin
                            re_d    = 1'b1;
                            tmr_val = TmrW'(ReadLatency + 1);
                            state_d = BUS_RD;
                        end
                    end else begin
                        nbytes_d = nbytes_q + 1'b1;
                    end
                end else if (tmr_exp) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (bus.rx_valid_i) begin
                    wdata_d   = bus.rx_data_i;
                    we_d      = 1'b1;
                    tmr_clear = 1'b1;
                    state_d   = BUS_WR;
                end else if (tmr_exp) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            BUS_WR: begin
                err_d   = bus.rx_valid_i;
                txd_d   = RSP_ACK;
                state_d = RESP;
            end
            BUS_RD: begin
                err_d = bus.rx_valid_i;
                if (tmr_exp) begin
                    txd_d   = bus.bus_rdata_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                // A byte in the handshake cycle is still an overrun.
                err_d = bus.rx_valid_i;
                if (bus.tx_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            txd_q    <= '0;
            nbytes_q <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            txd_q    <= txd_d;
            nbytes_q <= nbytes_d;
            we_q     <= we_d;
            re_q     <= re_d;
            err_q    <= err_d;
        end
    end

    assign bus.bus_addr_o  = addr_q[address_width-1:0];
    assign bus.bus_wdata_o = wdata_q;
    assign bus.bus_we_o    = we_q;
    assign bus.bus_re_o    = re_q;
    assign bus.tx_data_o   = txd_q;
    assign bus.tx_valid_o  = (state_q == RESP);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.err_o       = err_q;
endmodule
